// File: rtl/word_field_reader_if.sv
// Handshake bundle for word_field_reader: word input, field output and
// end-of-word summary. The slave view is the unpacker itself; the master
// view is whatever drives words in and consumes fields.
interface word_field_reader_if #(
  parameter int FIELD_W = 5,
  parameter int ROWS    = 3,
  parameter int COLS    = 3
);
  localparam int WORD_W = ROWS * COLS * FIELD_W;

  logic               in_valid;
  logic               in_ready;
  logic [WORD_W-1:0]  in_word;
  logic               out_valid;
  logic               out_ready;
  logic [FIELD_W-1:0] out_field;
  logic [1:0]         out_row;
  logic [1:0]         out_col;
  logic               out_last;
  logic               sum_valid;
  logic [5:0]         sum_value;
  logic               all_ones;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_field, out_row, out_col, out_last,
           sum_valid, sum_value, all_ones
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_field, out_row, out_col, out_last,
           sum_valid, sum_value, all_ones
  );
endinterface

// File: rtl/word_field_reader.sv
// Receive-side unpacker: captures one packed field word, emits its fields
// most-significant first with row/column tags, then pulses a popcount summary.
module word_field_reader #(
  parameter int FIELD_W = 5,
  parameter int ROWS    = 3,
  parameter int COLS    = 3
) (
  input  logic                clk,
  input  logic                rst,
  word_field_reader_if.slave  bus
);
  localparam int WORD_W = ROWS * COLS * FIELD_W;

  typedef enum logic {IDLE, EMIT} state_e;

  state_e             state_q, state_d;
  // NOTE: a 2-state register turns any x/z bit of the incoming word into 0.
  bit   [WORD_W-1:0]  word_q, word_d;
  logic [1:0]         row_q, row_d;
  logic [1:0]         col_q, col_d;
  logic [5:0]         acc_q, acc_d;
  logic               sum_valid_q, sum_valid_d;
  logic               rdy_en_q;

  logic               capture;
  logic               advance;
  logic               at_last;
  logic [FIELD_W-1:0] cur_field;
  logic [2:0]         field_pop;

  // The word is shifted left after each field, so the current field is always on top.
  assign cur_field = word_q[WORD_W-1 -: FIELD_W];
  assign field_pop = 3'($countones(cur_field));
  assign at_last   = (row_q == 2'(ROWS)) && (col_q == 2'd1);
  assign capture   = (state_q == IDLE) && rdy_en_q && bus.in_valid;
  assign advance   = (state_q == EMIT) && bus.out_ready;

  // State register; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one word in, then stay in EMIT until the last field is taken.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture)            state_d = EMIT;
      EMIT:    if (advance && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on capture, shift and accumulate on each field handshake.
  always_comb begin
    word_d      = word_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    sum_valid_d = 1'b0;
    if (capture) begin
      word_d = bus.in_word;
      row_d  = 2'd1;
      col_d  = 2'(COLS);
      acc_d  = '0;
    end else if (advance) begin
      word_d      = word_q << FIELD_W;
      acc_d       = acc_q + 6'(field_pop);
      sum_valid_d = at_last;
      if (col_q == 2'd1) begin
        col_d = 2'(COLS);
        row_d = row_q + 2'd1;
      end else begin
        col_d = col_q - 2'd1;
      end
    end
  end

  // Datapath registers; rdy_en_q keeps in_ready low until the first edge after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= '0;
      sum_valid_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      word_q      <= word_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      sum_valid_q <= sum_valid_d;
      rdy_en_q    <= 1'b1;
    end
  end

  // Outputs: field and tags are forced to zero outside EMIT.
  always_comb begin
    bus.in_ready  = (state_q == IDLE) && rdy_en_q;
    bus.out_valid = (state_q == EMIT);
    bus.out_field = '0;
    bus.out_row   = '0;
    bus.out_col   = '0;
    bus.out_last  = 1'b0;
    if (state_q == EMIT) begin
      bus.out_field = cur_field;
      bus.out_row   = row_q;
      bus.out_col   = col_q;
      bus.out_last  = at_last;
    end
    bus.sum_valid = sum_valid_q;
    bus.sum_value = acc_q;
    bus.all_ones  = (acc_q == 6'(WORD_W));
  end
endmodule

// File: tb/tb_word_field_reader.sv
// Self-checking bench for word_field_reader: directed cases plus randomized
// words and stalls, compared against a field/popcount model of the word.
module tb_word_field_reader;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  word_field_reader_if #(.FIELD_W(5), .ROWS(3), .COLS(3)) bus ();

  word_field_reader #(.FIELD_W(5), .ROWS(3), .COLS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog");
  end

  // Field k counts from the most-significant end: bits [44-5k -: 5].
  function automatic logic [4:0] field_of(input bit [44:0] w, input int k);
    return 5'((w >> (5 * (8 - k))) & 45'h1F);
  endfunction

  function automatic int popcnt(input bit [44:0] w);
    int n = 0;
    for (int i = 0; i < 45; i++) n += int'(w[i]);
    return n;
  endfunction

  task automatic send(input logic [44:0] w, input bit hold);
    int t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL send_wait_ready: in_ready=%b after %0d cycles, required 1", bus.in_ready, t);
    end
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    @(negedge clk);
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.in_word  = {$urandom, $urandom};
    end
  endtask

  // Entered in the first EMIT cycle. Checks every field cycle, optional stall
  // of stall_n cycles at field stall_k, optional reset at field abort_k.
  task automatic emit(input logic [44:0] w, input int stall_k, input int stall_n, input int abort_k);
    bit [44:0]   wm = w;
    int          k = 0;
    int          stalls = 0;
    int          cyc = 0;
    int          pop;
    logic [12:0] got13, exp13;
    logic [9:0]  got10, exp10;
    pop = popcnt(wm);
    while (k < 9 && cyc < 40) begin
      got13 = {bus.out_valid, bus.out_field, bus.out_row, bus.out_col, bus.out_last,
               bus.in_ready, bus.sum_valid};
      exp13 = {1'b1, field_of(wm, k), 2'(1 + k / 3), 2'(3 - k % 3), k == 8, 1'b0, 1'b0};
      checks++;
      if (got13 !== exp13) begin
        failures++;
        $display("FAIL field_k%0d: {valid,field,row,col,last,in_ready,sum_valid} got %b required %b",
                 k, got13, exp13);
      end
      if (k == abort_k) begin
        rst           = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        got13 = {bus.out_valid, bus.out_field, bus.out_row, bus.out_col, bus.out_last,
                 bus.in_ready, bus.sum_valid};
        checks++;
        if (got13 !== 13'd0 || bus.sum_value !== 6'd0 || bus.all_ones !== 1'b0) begin
          failures++;
          $display("FAIL abort_reset: outputs %b sum=%0d all_ones=%b, required all zero",
                   got13, bus.sum_value, bus.all_ones);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          checks++;
          if (bus.sum_valid !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_sum: sum_valid=%b out_valid=%b, required 0 0",
                     bus.sum_valid, bus.out_valid);
          end
        end
        return;
      end
      if (k == stall_k && stalls < stall_n) begin
        bus.out_ready = 1'b0;
        stalls++;
      end else begin
        bus.out_ready = 1'b1;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.out_ready = 1'b1;
    checks++;
    if (cyc !== 9 + stall_n) begin
      failures++;
      $display("FAIL emit_latency: %0d field cycles, required %0d", cyc, 9 + stall_n);
    end
    got10 = {bus.sum_valid, bus.sum_value, bus.all_ones, bus.in_ready, bus.out_valid};
    exp10 = {1'b1, 6'(pop), pop == 45, 1'b1, 1'b0};
    checks++;
    if (got10 !== exp10) begin
      failures++;
      $display("FAIL summary: {sum_valid,sum_value,all_ones,in_ready,out_valid} got %b required %b",
               got10, exp10);
    end
    if (bus.in_valid === 1'b1) begin
      // The held word is taken the moment IDLE is reached; the summary clears.
      @(negedge clk);
      bus.in_valid = 1'b0;
      got13 = {bus.out_valid, bus.sum_valid, bus.sum_value, bus.out_field};
      exp13 = {1'b1, 1'b0, 6'd0, field_of(wm, 0)};
      checks++;
      if (got13 !== exp13) begin
        failures++;
        $display("FAIL held_accept: {out_valid,sum_valid,sum_value,field} got %b required %b",
                 got13, exp13);
      end
    end else begin
      @(negedge clk);
      got10 = {2'b00, bus.sum_valid, bus.sum_value, bus.all_ones};
      exp10 = {2'b00, 1'b0, 6'(pop), pop == 45};
      checks++;
      if (got10 !== exp10) begin
        failures++;
        $display("FAIL summary_hold: {sum_valid,sum_value,all_ones} got %b required %b",
                 got10[8:0], exp10[8:0]);
      end
    end
  endtask

  task automatic test_reset;
    logic [19:0] got;
    int t = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    got = {bus.in_ready, bus.out_valid, bus.out_field, bus.out_row, bus.out_col,
           bus.out_last, bus.sum_valid, bus.sum_value, bus.all_ones};
    checks++;
    if (got !== 20'd0) begin
      failures++;
      $display("FAIL reset_values: outputs got %b required all zero", got);
    end
    rst = 1'b0;
    while (bus.in_ready !== 1'b1 && t < 3) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed;
    send(45'h1F0000000000, 1'b0);
    emit(45'h1F0000000000, -1, 0, -1);
    send(45'h000000000001, 1'b0);
    emit(45'h000000000001, -1, 0, -1);
    send(45'h1FFFFFFFFFFF, 1'b0);
    emit(45'h1FFFFFFFFFFF, -1, 0, -1);
  endtask

  task automatic test_backpressure;
    logic [44:0] w = 45'h0ABCDE123456;
    send(w, 1'b1);
    emit(w, 4, 3, -1);
    emit(w, -1, 0, -1);
  endtask

  task automatic test_reset_mid;
    send(45'h155555555555, 1'b0);
    emit(45'h155555555555, -1, 0, 5);
    send(45'h000000000021, 1'b0);
    emit(45'h000000000021, -1, 0, -1);
  endtask

  task automatic test_x_bit;
    logic [44:0] w;
    w    = '0;
    w[0] = 1'bx;
    send(w, 1'b0);
    emit(w, -1, 0, -1);
  endtask

  task automatic test_random;
    logic [44:0] w;
    for (int i = 0; i < 20; i++) begin
      w = 45'({$urandom, $urandom});
      if ($urandom_range(0, 7) == 0) w = '1;
      send(w, 1'b0);
      emit(w, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)), -1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_x_bit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
